pc_branch_seq: RTL and testbench
================================

Name: pc_branch_seq

Overview:
- Holds the 32-bit program counter and sequences conditional branches.
- Sits directly downstream of the CON flip-flop logic. It drives that stage's CONin enable, waits one cycle for the CON result, then either loads the captured branch target into the PC or leaves the PC unchanged.
- Also performs the normal fetch-time PC increment.
- Serves as the datapath's single PC owner; the control unit only issues requests.

Parameters:
- PC_W, 32, width of PC, target bus and increment arithmetic.
- RESET_PC, 0, value loaded into PC on reset.
- INC_STEP, 4, amount added to PC on each increment request.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- inc_req  in  1  one-cycle request: PC <= PC + INC_STEP.
- br_start  in  1  one-cycle request to begin a conditional branch; target sampled from busin the same cycle.
- busin  in  PC_W  branch target address (bus value at br_start).
- con  in  1  CON flip-flop output (branch condition met).
- con_in  out  1  enable pulse to CON flip-flop (its CONin).
- pc  out  PC_W  current program counter.
- busy  out  1  branch sequence in progress.
- done  out  1  one-cycle pulse: branch sequence finished.
- taken  out  1  result of the last completed branch; valid from done until the next br_start is accepted.

Behaviour:
- Reset (clear=1 at a rising edge, any state):
  - pc=RESET_PC; state=IDLE; con_in=0, busy=0, done=0, taken=0; target register=0.
  - clear has priority over every other input.
- States: IDLE, EVAL, SAMPLE, UPDATE. All outputs are registered.
- IDLE:
  - inc_req=1 -> pc <= pc + INC_STEP, modulo 2^PC_W (0xFFFFFFFC + 4 = 0x00000000, no flag).
  - br_start=1 -> target <= busin; taken <= 0; state -> EVAL; busy=1 next cycle.
  - inc_req and br_start in the same cycle: both accepted. The increment applies this edge; the target is captured this edge.
- EVAL (1 cycle):
  - con_in=1 for exactly this cycle. The CON stage latches its condition at the end of this cycle.
  - Next state SAMPLE.
- SAMPLE (1 cycle):
  - con is valid.
  - taken <= con; next state UPDATE.
- UPDATE (1 cycle):
  - taken=1 -> pc <= target; taken=0 -> pc unchanged.
  - done=1 this cycle; next state IDLE; busy=0 from the next cycle.
- Latency:
  - br_start at cycle N -> con_in high in cycle N+1.
  - taken valid in cycle N+3, together with done.
  - New pc visible in cycle N+4.
  - Next br_start can be accepted in cycle N+4.
- While busy=1:
  - br_start and inc_req are ignored; no queueing.
  - busin changes have no effect; the target is frozen at capture.
- con is sampled only in SAMPLE; con changes in any other state are ignored.
- clear asserted in EVAL, SAMPLE or UPDATE aborts the sequence:
  - no pc load; done is not pulsed; pc=RESET_PC.
- busy=1 exactly in EVAL, SAMPLE, UPDATE.
- done never overlaps con_in.

Test Plan:
- Reset: clear held 2 cycles with inc_req=1, br_start=1 -> pc=0, busy=0, done=0, taken=0, con_in=0.
- Increment and wrap: 3 inc_req pulses from reset -> pc=12. Preload pc=0xFFFFFFFC via a taken branch, then inc_req -> pc=0x00000000.
- Taken branch: pc=0x10, br_start with busin=0x0000_0400, con=1 in SAMPLE -> con_in high 1 cycle at N+1; done and taken=1 at N+3; pc=0x400 at N+4; busy high N+1..N+3.
- Not-taken branch: same stimulus with con=0, and busin changed to 0xDEAD in N+1 -> taken=0, done at N+3, pc stays 0x10.
- Ignored requests: br_start and inc_req pulsed at N+2 during a taken branch to 0x800 -> pc=0x800 at N+4; no second con_in; no extra increment.
- Simultaneous and abort cases:
  - inc_req with br_start at pc=0x20, target 0x100, con=1 -> pc=0x24 at N+1, then 0x100 at N+4.
  - Separate run: clear asserted at N+2 -> pc=0, no done pulse, busy=0 at N+3.

Source files
------------

// File: rtl/pc_branch_seq.sv
// Program counter owner: fetch-time increment plus a 4-cycle conditional branch sequence (start -> CONin -> sample CON -> load).
// Branch load lands 4 cycles after br_start; requests arriving while busy are dropped, never queued.
module pc_branch_seq #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INC_STEP = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            inc_req,
    input  logic            br_start,
    input  logic [PC_W-1:0] busin,
    input  logic            con,
    output logic            con_in,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            taken
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] STEP = PC_W'(INC_STEP);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc_d;
    logic [PC_W-1:0] tgt_q;
    logic            con_in_q;
    logic            busy_q;
    logic            done_q;
    logic            taken_q;

    // Wraps silently modulo 2^PC_W.
    assign pc_inc_d = pc_q + STEP;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            tgt_q    <= '0;
            con_in_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            con_in_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (inc_req) begin
                        pc_q <= pc_inc_d;
                    end
                    if (br_start) begin
                        tgt_q    <= busin;
                        taken_q  <= 1'b0;
                        con_in_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= EVAL;
                    end
                end
                EVAL: begin
                    state_q <= SAMPLE;
                end
                SAMPLE: begin
                    // CON stage latched its result at the end of EVAL.
                    taken_q <= con;
                    done_q  <= 1'b1;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    if (taken_q) begin
                        pc_q <= tgt_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign con_in = con_in_q;
    assign pc     = pc_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign taken  = taken_q;

endmodule

// File: tb/tb_pc_branch_seq.sv
// Randomized and directed bench for pc_branch_seq against a cycle-offset reference model.
module tb_pc_branch_seq;

    logic        clk = 1'b0;
    logic        clear, inc_req, br_start, con;
    logic [31:0] busin;
    logic        con_in, busy, done, taken;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a branch is described only by the cycle it started in.
    int          cyc_no   = 0;
    int          br_cyc   = -100;
    logic [31:0] m_pc     = 32'h0;
    logic [31:0] m_tgt    = 32'h0;
    logic        m_taken  = 1'b0;

    pc_branch_seq #(.PC_W(32), .RESET_PC(32'h0), .INC_STEP(4)) dut (
        .clock   (clk),
        .clear   (clear),
        .inc_req (inc_req),
        .br_start(br_start),
        .busin   (busin),
        .con     (con),
        .con_in  (con_in),
        .pc      (pc),
        .busy    (busy),
        .done    (done),
        .taken   (taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic i_inc, input logic i_br, input logic [31:0] i_bus,
                         input logic i_con, input logic i_clr);
        int  off;
        logic act;
        inc_req  = i_inc;
        br_start = i_br;
        busin    = i_bus;
        con      = i_con;
        clear    = i_clr;
        off = cyc_no - br_cyc;
        act = (off >= 1) && (off <= 3);
        @(negedge clk);
        check("con_in", {31'h0, con_in}, {31'h0, act && off == 1});
        check("busy",   {31'h0, busy},   {31'h0, act});
        check("done",   {31'h0, done},   {31'h0, act && off == 3});
        check("taken",  {31'h0, taken},  {31'h0, m_taken});
        check("pc",     pc,              m_pc);
        @(posedge clk);
        if (i_clr) begin
            m_pc = 32'h0; m_tgt = 32'h0; m_taken = 1'b0; br_cyc = -100;
        end else if (!act) begin
            if (i_inc) m_pc = m_pc + 32'd4;
            if (i_br) begin
                m_tgt = i_bus; m_taken = 1'b0; br_cyc = cyc_no;
            end
        end else begin
            if (off == 2) m_taken = i_con;
            if (off == 3) begin
                if (m_taken) m_pc = m_tgt;
                br_cyc = -100;
            end
        end
        cyc_no++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic reset_to(input int incs);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < incs; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        inc_req = 0; br_start = 0; busin = 0; con = 0; clear = 1;
        @(posedge clk); #1;

        // Reset with competing requests held active.
        cycle(1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
        check("rst_pc", pc, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_con_in", {31'h0, con_in}, 32'h0);

        // Three increments from reset.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("inc3_pc", pc, 32'd12);

        // Taken branch from 0x10 to 0x400.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_taken_pc", pc, 32'h10);
        cycle(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("taken_n3_done", {31'h0, done}, 32'h1);
        check("taken_n3_taken", {31'h0, taken}, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("taken_n4_pc", pc, 32'h400);
        check("taken_n4_busy", {31'h0, busy}, 32'h0);

        // Not-taken branch; bus changes after capture.
        reset_to(4);
        cycle(1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'hDEAD, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'hDEAD, 1'b0, 1'b0);
        check("nt_n3_taken", {31'h0, taken}, 32'h0);
        check("nt_n3_done", {31'h0, done}, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("nt_n4_pc", pc, 32'h10);

        // Requests during a branch are dropped.
        cycle(1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h123, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("ign_pc", pc, 32'h800);
        check("ign_con_in", {31'h0, con_in}, 32'h0);
        idle(2);

        // Increment and branch accepted together.
        reset_to(8);
        check("sim_pre_pc", pc, 32'h20);
        cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        check("sim_n1_pc", pc, 32'h24);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("sim_n4_pc", pc, 32'h100);

        // Abort in SAMPLE.
        cycle(1'b0, 1'b1, 32'h700, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("abort_pc", pc, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        idle(3);

        // Wrap: load 0xFFFFFFFC then increment.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
